acc_src_unit: RTL and testbench

Parametrised successor of the three-way accumulator-A source selector. Picks one of `N_SRC` operand channels (data memory, immediate, arithmetic result, …), sign-extends the immediate channel, and loads the value into an owned accumulator register. A valid-qualified wait state handles sources that are not ready in the request cycle. Sits between the decoder/datapath sources and the ALU A-operand input of the accumulator CPU.

---
 rtl/acc_src_pkg.sv | 14 +
 rtl/sign_ext.sv | 13 +
 rtl/acc_src_unit.sv | 135 +++++++++++++
 tb/tb_acc_src_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/acc_src_pkg.sv
// Shared definitions for the accumulator-A source selector: FSM state encoding
// and the default channel map used by the decoder and datapath.
package acc_src_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam int CH_DATA = 0;
  localparam int CH_IMM  = 1;
  localparam int CH_ARIT = 2;

endpackage : acc_src_pkg

// File: rtl/sign_ext.sv
// Two's-complement sign extension of an IN_W-bit field to OUT_W bits.
// Shared between this unit and the instruction decoder.
module sign_ext #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  i_data,
  output logic [OUT_W-1:0] o_data
);

  assign o_data = OUT_W'($signed(i_data));

endmodule : sign_ext

// File: rtl/acc_src_unit.sv
// Accumulator-A source selector: picks one of N_SRC channels, sign-extends the
// immediate channel and loads the owned accumulator, waiting for late sources.
module acc_src_unit
  import acc_src_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int N_SRC    = 3,
  parameter int IMM_CH   = CH_IMM,
  parameter int IMM_W    = 11,
  parameter int WAIT_MAX = 7
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [$clog2(N_SRC)-1:0]  i_sel,
  input  logic [N_SRC*DATA_W-1:0]   i_src,
  input  logic [N_SRC-1:0]          i_src_valid,
  input  logic                      i_err_clr,
  output logic [DATA_W-1:0]         o_acc,
  output logic                      o_acc_valid,
  output logic                      o_zero,
  output logic                      o_neg,
  output logic                      o_err
);

  localparam int SEL_W = $clog2(N_SRC);
  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  state_e              r_state;
  logic [SEL_W-1:0]    r_sel_q;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [DATA_W-1:0]   r_acc;
  logic                r_acc_valid;
  logic                r_zero;
  logic                r_neg;
  logic                r_err;

  logic [DATA_W-1:0]   w_imm_ext;
  logic [DATA_W-1:0]   w_ext [N_SRC];
  logic [SEL_W-1:0]    w_cur_sel;
  logic                w_sel_legal;
  logic                w_sel_valid;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_load;
  logic                w_timeout;
  logic                w_illegal;

  sign_ext #(
    .IN_W  (IMM_W),
    .OUT_W (DATA_W)
  ) u_imm_ext (
    .i_data (i_src[IMM_CH*DATA_W +: IMM_W]),
    .o_data (w_imm_ext)
  );

  for (genvar k = 0; k < N_SRC; k++) begin : g_ext
    assign w_ext[k] = (k == IMM_CH) ? w_imm_ext : i_src[k*DATA_W +: DATA_W];
  end

  // In WAIT_SRC the latched select drives the mux; the live i_sel is ignored.
  assign w_cur_sel   = (r_state == ST_IDLE) ? i_sel : r_sel_q;
  assign w_sel_legal = ({1'b0, w_cur_sel} < (SEL_W+1)'(N_SRC));

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (w_cur_sel == SEL_W'(k)) begin
        w_sel_data  = w_ext[k];
        w_sel_valid = i_src_valid[k];
      end
    end
  end

  // A load on the last wait cycle pre-empts the timeout, so the two never coincide.
  assign w_load    = w_sel_valid && ((r_state == ST_IDLE && i_valid) || r_state == ST_WAIT);
  assign w_timeout = (r_state == ST_WAIT) && !w_sel_valid &&
                     (r_wait_cnt == CNT_W'(WAIT_MAX - 1));
  assign w_illegal = (r_state == ST_IDLE) && i_valid && !w_sel_legal;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_sel_q     <= '0;
      r_wait_cnt  <= '0;
      r_acc       <= '0;
      r_acc_valid <= 1'b0;
      r_zero      <= 1'b1;
      r_neg       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_acc_valid <= w_load;
      if (w_load) begin
        r_acc  <= w_sel_data;
        r_zero <= (w_sel_data == '0);
        r_neg  <= w_sel_data[DATA_W-1];
      end

      if (w_illegal || w_timeout) begin
        r_err <= 1'b1;
      end else if (i_err_clr) begin
        r_err <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_valid && w_sel_legal && !w_sel_valid) begin
            r_sel_q    <= i_sel;
            r_wait_cnt <= '0;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_sel_valid || w_timeout) begin
            r_state <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready     = (r_state == ST_IDLE);
  assign o_acc       = r_acc;
  assign o_acc_valid = r_acc_valid;
  assign o_zero      = r_zero;
  assign o_neg       = r_neg;
  assign o_err       = r_err;

endmodule : acc_src_unit

// File: tb/tb_acc_src_unit.sv
// Randomized scoreboard bench for acc_src_unit: the driver predicts each load
// (value and edge) into a queue, a negedge monitor pops and compares on o_acc_valid.
module tb_acc_src_unit;

  localparam int DATA_W   = 16;
  localparam int N_SRC    = 3;
  localparam int IMM_CH   = 1;
  localparam int IMM_W    = 11;
  localparam int WAIT_MAX = 7;

  logic                    i_clk;
  logic                    i_rst_n;
  logic                    i_valid;
  logic                    o_ready;
  logic [1:0]              i_sel;
  logic [N_SRC*DATA_W-1:0] i_src;
  logic [N_SRC-1:0]        i_src_valid;
  logic                    i_err_clr;
  logic [DATA_W-1:0]       o_acc;
  logic                    o_acc_valid;
  logic                    o_zero;
  logic                    o_neg;
  logic                    o_err;

  acc_src_unit #(
    .DATA_W   (DATA_W),
    .N_SRC    (N_SRC),
    .IMM_CH   (IMM_CH),
    .IMM_W    (IMM_W),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_sel       (i_sel),
    .i_src       (i_src),
    .i_src_valid (i_src_valid),
    .i_err_clr   (i_err_clr),
    .o_acc       (o_acc),
    .o_acc_valid (o_acc_valid),
    .o_zero      (o_zero),
    .o_neg       (o_neg),
    .o_err       (o_err)
  );

  typedef struct {
    logic [15:0] acc;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [15:0] m_acc    = 16'h0000;
  bit          m_err    = 1'b0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference extension: immediate channel takes its low 11 bits as a signed number.
  function automatic logic [15:0] ref_ext(input int sel, input logic [15:0] x);
    if (sel == IMM_CH) return ((x & 16'h07FF) ^ 16'h0400) - 16'h0400;
    return x;
  endfunction

  task automatic rand_channels(input int keep_sel, input logic [15:0] keep_data);
    i_src = {16'($urandom), 16'($urandom), 16'($urandom)};
    if (keep_sel < N_SRC) i_src[keep_sel*DATA_W +: DATA_W] = keep_data;
  endtask

  // One request: source sel becomes valid after d cycles of being low (d=0: ready now).
  task automatic req(input int sel, input logic [15:0] data, input int d, input bit clr);
    check("ready_before_req", 32'(o_ready), 32'd1);
    rand_channels(sel, data);
    i_src_valid = 3'($urandom);
    if (sel < N_SRC) i_src_valid[sel] = (d == 0);
    i_valid   = 1'b1;
    i_sel     = 2'(sel);
    i_err_clr = clr;
    if (clr) m_err = 1'b0;
    if (sel >= N_SRC) begin
      m_err = 1'b1;
    end else if (d <= WAIT_MAX) begin
      m_acc = ref_ext(sel, data);
      exp_q.push_back('{acc: m_acc, cyc: cyc + 1 + d});
    end else begin
      m_err = 1'b1;
    end
    @(posedge i_clk); #1;
    i_valid   = 1'b0;
    i_err_clr = 1'b0;
    i_sel     = 2'($urandom);
    if (sel < N_SRC && d > 0) begin
      for (int c = 1; c <= WAIT_MAX; c++) begin
        check("ready_in_wait", 32'(o_ready), 32'd0);
        rand_channels(sel, data);
        i_src_valid = 3'($urandom);
        i_src_valid[sel] = (c >= d);
        @(posedge i_clk); #1;
        if (c >= d) break;
      end
    end
    check("err_after_req", 32'(o_err), 32'(m_err));
    check("ready_after_req", 32'(o_ready), 32'd1);
    check("acc_after_req", 32'(o_acc), 32'(m_acc));
  endtask

  task automatic clear_err();
    i_err_clr = 1'b1;
    @(posedge i_clk); #1;
    i_err_clr = 1'b0;
    m_err = 1'b0;
    check("err_cleared", 32'(o_err), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_acc"},       32'(o_acc),       32'd0);
    check({tag, "_acc_valid"}, 32'(o_acc_valid), 32'd0);
    check({tag, "_zero"},      32'(o_zero),      32'd1);
    check({tag, "_neg"},       32'(o_neg),       32'd0);
    check({tag, "_err"},       32'(o_err),       32'd0);
    check({tag, "_ready"},     32'(o_ready),     32'd1);
  endtask

  // Monitor: every load pulse must match the oldest prediction, including its edge.
  always @(negedge i_clk) begin
    if (i_rst_n && o_acc_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_acc_valid actual acc=%h expected no pulse (cycle %0d)", o_acc, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_acc",     32'(o_acc),  32'(e.acc));
        check("mon_zero",    32'(o_zero), 32'(e.acc == 16'h0000));
        check("mon_neg",     32'(o_neg),  32'(e.acc[15]));
        check("mon_latency", 32'(cyc),    32'(e.cyc));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst_n     = 1'b0;
    i_valid     = 1'b0;
    i_sel       = '0;
    i_src       = '0;
    i_src_valid = '0;
    i_err_clr   = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_values("reset");
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check_reset_values("post_reset");

    req(1, 16'h07FF, 0, 1'b0);
    req(1, 16'h03FF, 0, 1'b0);
    req(1, 16'hF400, 0, 1'b0);
    req(0, 16'hF800, 0, 1'b0);
    req(2, 16'h0000, 0, 1'b0);
    req(2, 16'h001F, 4, 1'b0);
    req(2, 16'h8001, 1, 1'b0);
    req(0, 16'h1234, WAIT_MAX, 1'b0);
    req(2, 16'h5555, WAIT_MAX + 1, 1'b0);
    clear_err();
    req(3, 16'hAAAA, 0, 1'b0);
    req(3, 16'hBBBB, 0, 1'b1);
    clear_err();
    req(2, 16'h6666, WAIT_MAX + 3, 1'b1);
    clear_err();

    req(0, 16'h7E57, 0, 1'b0);
    rand_channels(3, 16'h0000);
    i_src_valid = 3'b000;
    i_valid = 1'b1;
    i_sel   = 2'd2;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("ready_before_reset", 32'(o_ready), 32'd0);
    i_rst_n = 1'b0;
    #1;
    check_reset_values("mid_wait_reset");
    i_src_valid = 3'b111;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    m_acc = 16'h0000;
    m_err = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_values("after_dropped_req");
    i_src_valid = 3'b000;

    for (int n = 0; n < 80; n++) begin
      int sel;
      int d;
      sel = int'($urandom_range(0, 3));
      d   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, WAIT_MAX + 2));
      req(sel, 16'($urandom), d, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 5) == 0) clear_err();
    end

    repeat (3) @(posedge i_clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_acc_src_unit
